// File: rtl/cacheline_arb_pkg.sv
// Shared types for the cacheline arbiter.
// FSM states, requester ids and the line type.
package cacheline_arb_pkg;

  localparam int LINE_BITS = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

  typedef logic [LINE_BITS-1:0] line_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async high), inc, clr, count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != {W{1'b1}}) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one burst engine between icache and dcache.
// Ports: icache_* / dcache_* requesters, line_* burst engine, debug counters.
module cacheline_arbiter
  import cacheline_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_read,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic [ADDR_W-1:0] line_addr,
  output logic              line_read,
  output logic              line_write,
  output logic [LINE_W-1:0] line_wdata,
  input  logic [LINE_W-1:0] line_rdata,
  input  logic              line_resp,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  icache_grants,
  output logic [CNT_W-1:0]  dcache_grants
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state;
  requester_t        last_grant;
  requester_t        owner;
  logic [ADDR_W-1:0] hold_addr;
  logic [LINE_W-1:0] hold_wdata;
  logic [LINE_W-1:0] cap_rdata;
  logic [WD_W-1:0]   wd_count;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic grant;

  assign i_req  = icache_read;
  assign d_req  = dcache_read | dcache_write;
  // dcache wins when alone, or on a tie when icache went last.
  assign pick_d = d_req & (~i_req | (last_grant == REQ_I));
  assign grant  = (state == IDLE) & (i_req | d_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= REQ_D;
      owner       <= REQ_I;
      hold_addr   <= '0;
      hold_wdata  <= '0;
      cap_rdata   <= '0;
      line_read   <= 1'b0;
      line_write  <= 1'b0;
      icache_resp <= 1'b0;
      dcache_resp <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner      <= pick_d ? REQ_D : REQ_I;
            last_grant <= pick_d ? REQ_D : REQ_I;
            hold_addr  <= pick_d ? dcache_addr : icache_addr;
            hold_wdata <= pick_d ? dcache_wdata : '0;
            // write beats read if the dcache raises both
            line_write <= pick_d & dcache_write;
            line_read  <= ~(pick_d & dcache_write);
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (line_resp) begin
            cap_rdata   <= line_write ? '0 : line_rdata;
            line_read   <= 1'b0;
            line_write  <= 1'b0;
            icache_resp <= (owner == REQ_I);
            dcache_resp <= (owner == REQ_D);
            state       <= DONE;
          end
        end
        DONE: begin
          icache_resp <= 1'b0;
          dcache_resp <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (state == BUSY && wd_count == WD_LAST) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign line_addr    = hold_addr;
  assign line_wdata   = hold_wdata;
  assign icache_rdata = icache_resp ? cap_rdata : '0;
  assign dcache_rdata = dcache_resp ? cap_rdata : '0;

  sat_counter #(.W(CNT_W)) u_icnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (grant & ~pick_d),
    .clr   (1'b0),
    .count (icache_grants)
  );

  sat_counter #(.W(CNT_W)) u_dcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (grant & pick_d),
    .clr   (1'b0),
    .count (dcache_grants)
  );

  // Restarts on every grant; counts cycles spent in BUSY.
  sat_counter #(.W(WD_W)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .inc   (state == BUSY),
    .clr   (grant),
    .count (wd_count)
  );

endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
Round-robin arbiter sharing the single 256-bit cacheline burst engine between the instruction cache (read-only) and the data cache (read/write). It replaces ad-hoc combinational muxing with registered grant and request-hold state, so downstream addr, op and wdata stay stable for the whole burst. It sits between the L1 caches and the burst engine, adds fixed 2-cycle overhead, and exposes a watchdog error and per-requester grant counters for debug.

Parameters:
ADDR_W, 32, line address width
LINE_W, 256, cacheline width in bits
TIMEOUT_CYCLES, 1024, max cycles in BUSY before timeout_err sets
CNT_W, 16, width of saturating grant counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
icache_addr  in  ADDR_W  icache line address
icache_read  in  1  icache read request, level, held until icache_resp
icache_rdata  out  LINE_W  line data, valid only while icache_resp=1
icache_resp  out  1  one-cycle completion pulse
dcache_addr  in  ADDR_W  dcache line address
dcache_read  in  1  dcache read request, level
dcache_write  in  1  dcache writeback request, level
dcache_wdata  in  LINE_W  writeback line
dcache_rdata  out  LINE_W  line data, valid only while dcache_resp=1
dcache_resp  out  1  one-cycle completion pulse
line_addr  out  ADDR_W  to burst engine, held stable in BUSY
line_read  out  1  to burst engine, level until line_resp
line_write  out  1  to burst engine, level until line_resp
line_wdata  out  LINE_W  to burst engine, held stable in BUSY
line_rdata  in  LINE_W  from burst engine, valid with line_resp
line_resp  in  1  burst complete, one-cycle pulse
timeout_err  out  1  sticky; set when a BUSY phase exceeds TIMEOUT_CYCLES
icache_grants  out  CNT_W  saturating count of icache grants
dcache_grants  out  CNT_W  saturating count of dcache grants

Behaviour:
- Reset: clk and rst only. rst is asynchronous, active-high. On reset, all outputs are 0, state=IDLE, last_grant=DCACHE (icache wins the first tie), and counters and timeout_err are 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one requester is active, grant it.
  - If both are active, grant the requester that is not last_grant.
  - On grant, the next edge captures addr, op and wdata into hold registers, updates last_grant, increments that grant counter (saturating at all-ones), and moves to BUSY.
- dcache_read and dcache_write both high: write wins, read ignored (illegal; bench asserts it never occurs). Downstream rdata is discarded for writes.
- BUSY:
  - line_read or line_write is driven from the hold registers. line_addr and line_wdata come only from hold registers, never from live inputs.
  - Watchdog counter increments each cycle. On reaching TIMEOUT_CYCLES, timeout_err sets and stays set until rst. The arbiter keeps waiting (no abort).
  - On line_resp: capture line_rdata, deassert line_read/line_write on the next edge, move to DONE.
- DONE:
  - The granted requester's resp=1 for exactly one cycle, with rdata driven from the capture register. The other requester's resp and rdata are 0.
  - Next state is IDLE.
  - The DONE cycle keeps the requester's still-high request from being re-granted.
- Latency: request seen in IDLE at cycle 0 -> line strobe at cycle 1. line_resp at cycle N -> requester resp at N+1. The next grant is no earlier than N+2.
- Requests arriving mid-BUSY wait. Requests that deassert before grant are not an error; they are simply not granted.
- line_resp outside BUSY is ignored.
- Back-to-back requests from a single requester are each served. Alternation applies only when both requesters are pending in the same IDLE cycle.
- Reset mid-BUSY: outputs drop asynchronously. The burst engine shares the same rst.

Decomposition:
- Package cacheline_arb_pkg:
  - arb_state_t enum {IDLE, BUSY, DONE}
  - requester_t enum {REQ_I, REQ_D}
  - line_t = logic [LINE_W-1:0]
- Sub-module sat_counter (parameter W, inputs inc and clr, saturating). It is instantiated for both grant counters and for the watchdog (cleared on entry to BUSY).

Test Plan:
- icache_read=1, addr=0x0000_1000; line_resp with rdata=0xA5..A5 four cycles after line_read -> line_read rises at cycle 1, icache_resp at cycle 6 carrying 0xA5..A5, icache_grants=1.
- icache_read and dcache_read rise together, addrs 0x100/0x200, both held -> grants in order icache then dcache; line_addr is 0x100 then 0x200 with no overlap.
- dcache_write, addr 0x40, wdata 0xDEAD..BEEF; dcache_addr/wdata changed to junk after grant -> line_addr=0x40 and line_wdata=0xDEAD..BEEF throughout BUSY; dcache_resp pulses once.
- Both requesters continuously re-request for 8 transactions -> strictly alternating grants, icache_grants=dcache_grants=4.
- TIMEOUT_CYCLES=16, line_resp withheld 20 cycles -> timeout_err=1 at BUSY cycle 16, sticky after the later line_resp completes normally.
- rst asserted mid-BUSY -> line_read=0 immediately without waiting for clk; after release, a fresh icache_read is granted normally with counters at 0.
